stack_mem_ctrl: RTL and testbench

//  Request-side controller sitting directly upstream of the 256x8 data memory (dat_mem).

---
 rtl/stack_mem_ctrl_pkg.sv | 29 ++
 rtl/stack_mem_ctrl_if.sv | 38 +++
 rtl/stack_mem_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_stack_mem_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_mem_ctrl_pkg.sv
// rtl/stack_mem_ctrl_pkg.sv - shared types and constants for the stack/memory request controller
//
// Purpose: request opcode encoding, controller FSM states and the default
//          stack window, shared by the controller, its interface users and the bench.
// Ports:   none (package).
package stack_mem_ctrl_pkg;

  // Request opcodes; encodings 6 and 7 are illegal.
  typedef enum logic [2:0] {
    OP_LD    = 3'd0,
    OP_ST    = 3'd1,
    OP_PUSH  = 3'd2,
    OP_POP   = 3'd3,
    OP_PUSH2 = 3'd4,
    OP_POP2  = 3'd5
  } mem_op_t;

  // Empty-stack SP (first push lands here) and lowest stack address.
  // The window sits above the constant/mask table at words 60-72.
  localparam logic [7:0] STACK_BASE_DEF  = 8'd255;
  localparam logic [7:0] STACK_LIMIT_DEF = 8'd192;

  // IDLE accepts requests; SECOND is the second cycle of a 16-bit stack op.
  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/stack_mem_ctrl_if.sv
// rtl/stack_mem_ctrl_if.sv - request/response and data-memory port bundle for stack_mem_ctrl
//
// Purpose: groups the core-side request/response handshake and the dat_mem
//          single address/write port into one interface.
// Signals:
//   req_valid/req_ready/req_op/req_addr/req_wdata  core -> controller request
//   rsp_valid/rsp_data/rsp_err                      controller -> core completion
//   mem_addr/mem_wr_en/mem_din                      controller -> dat_mem
//   mem_dout                                        dat_mem -> controller (combinational read)
// Modports: slave = controller side, master = core plus memory side.
interface stack_mem_ctrl_if;

  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;

  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;

  logic [7:0]  mem_addr;
  logic        mem_wr_en;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_dout,
    output req_ready, rsp_valid, rsp_data, rsp_err, mem_addr, mem_wr_en, mem_din
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_dout,
    input  req_ready, rsp_valid, rsp_data, rsp_err, mem_addr, mem_wr_en, mem_din
  );

endinterface

// File: rtl/stack_mem_ctrl.sv
// rtl/stack_mem_ctrl.sv - load/store/push/pop request controller in front of the 256x8 dat_mem
//
// Purpose: accepts byte/halfword load, store, push and pop requests, owns the
//          downward-growing stack pointer and sequences dat_mem's single port.
//          16-bit stack ops take two cycles (IDLE -> SECOND -> IDLE).
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-high
//   bus      slave modport of stack_mem_ctrl_if (request, response, memory port)
//   sp       out  stack pointer, always the next free slot
//   err_ovf  out  sticky overflow flag, cleared only by reset
//   err_unf  out  sticky underflow flag, cleared only by reset
module stack_mem_ctrl
  import stack_mem_ctrl_pkg::*;
#(
  parameter logic [7:0] STACK_BASE  = STACK_BASE_DEF,
  parameter logic [7:0] STACK_LIMIT = STACK_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  stack_mem_ctrl_if.slave  bus,
  output logic [7:0]       sp,
  output logic             err_ovf,
  output logic             err_unf
);

  ctrl_state_t state;
  ctrl_state_t state_nxt;

  logic        accept;
  logic [8:0]  occupancy;
  logic [8:0]  free_slots;
  logic        can_push1;
  logic        can_push2;
  logic        can_pop1;
  logic        can_pop2;
  logic        start_two;
  logic        pop2_q;   // 1: SECOND belongs to a POP2, 0: to a PUSH2
  logic [7:0]  lo_q;     // PUSH2 low byte to write, or POP2 low byte read

  // 9-bit room arithmetic so the checks never depend on 8-bit wrap,
  // even when sp sits one below STACK_LIMIT (stack full).
  assign occupancy  = {1'b0, STACK_BASE} - {1'b0, sp};
  assign free_slots = {1'b0, sp} - {1'b0, STACK_LIMIT} + 9'd1;
  assign can_push1  = (free_slots >= 9'd1);
  assign can_push2  = (free_slots >= 9'd2);
  assign can_pop1   = (occupancy  >= 9'd1);
  assign can_pop2   = (occupancy  >= 9'd2);

  assign bus.req_ready = (state == IDLE);
  assign accept        = bus.req_valid && (state == IDLE);
  assign start_two     = accept &&
                         (((bus.req_op == OP_PUSH2) && can_push2) ||
                          ((bus.req_op == OP_POP2)  && can_pop2));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: only a legal 16-bit stack op leaves IDLE, SECOND lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_two) state_nxt = SECOND;
      SECOND:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory port mux: combinational from state and the request being accepted.
  always_comb begin
    bus.mem_addr  = 8'd0;
    bus.mem_wr_en = 1'b0;
    bus.mem_din   = 8'd0;
    case (state)
      IDLE: begin
        if (accept) begin
          case (bus.req_op)
            OP_LD: bus.mem_addr = bus.req_addr;
            OP_ST: begin
              bus.mem_addr  = bus.req_addr;
              bus.mem_wr_en = 1'b1;
              bus.mem_din   = bus.req_wdata[7:0];
            end
            OP_PUSH: if (can_push1) begin
              bus.mem_addr  = sp;
              bus.mem_wr_en = 1'b1;
              bus.mem_din   = bus.req_wdata[7:0];
            end
            OP_POP:  if (can_pop1) bus.mem_addr = sp + 8'd1;
            OP_PUSH2: if (can_push2) begin
              bus.mem_addr  = sp;
              bus.mem_wr_en = 1'b1;
              bus.mem_din   = bus.req_wdata[15:8];
            end
            OP_POP2: if (can_pop2) bus.mem_addr = sp + 8'd1;
            default: ;
          endcase
        end
      end
      SECOND: begin
        if (pop2_q) begin
          bus.mem_addr = sp + 8'd2;
        end else begin
          bus.mem_addr  = sp - 8'd1;
          bus.mem_wr_en = 1'b1;
          bus.mem_din   = lo_q;
        end
      end
      default: ;
    endcase
  end

  // Stack pointer, response and sticky flags. sp moves by two only at the end
  // of SECOND so both halves of a 16-bit op address from the same base.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp            <= STACK_BASE;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= 16'd0;
      bus.rsp_err   <= 1'b0;
      err_ovf       <= 1'b0;
      err_unf       <= 1'b0;
      pop2_q        <= 1'b0;
      lo_q          <= 8'd0;
    end else begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      if (state == SECOND) begin
        bus.rsp_valid <= 1'b1;
        if (pop2_q) begin
          bus.rsp_data <= {bus.mem_dout, lo_q};
          sp           <= sp + 8'd2;
        end else begin
          bus.rsp_data <= 16'd0;
          sp           <= sp - 8'd2;
        end
      end else if (accept) begin
        bus.rsp_data <= 16'd0;
        case (bus.req_op)
          OP_LD: begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_data  <= {8'h00, bus.mem_dout};
          end
          OP_ST: bus.rsp_valid <= 1'b1;
          OP_PUSH: begin
            bus.rsp_valid <= 1'b1;
            if (can_push1) begin
              sp <= sp - 8'd1;
            end else begin
              bus.rsp_err <= 1'b1;
              err_ovf     <= 1'b1;
            end
          end
          OP_POP: begin
            bus.rsp_valid <= 1'b1;
            if (can_pop1) begin
              bus.rsp_data <= {8'h00, bus.mem_dout};
              sp           <= sp + 8'd1;
            end else begin
              bus.rsp_err <= 1'b1;
              err_unf     <= 1'b1;
            end
          end
          OP_PUSH2: begin
            if (can_push2) begin
              lo_q   <= bus.req_wdata[7:0];
              pop2_q <= 1'b0;
            end else begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              err_ovf       <= 1'b1;
            end
          end
          OP_POP2: begin
            if (can_pop2) begin
              lo_q   <= bus.mem_dout;
              pop2_q <= 1'b1;
            end else begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              err_unf       <= 1'b1;
            end
          end
          default: begin
            // Illegal opcode: error response only, sticky flags untouched.
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stack_mem_ctrl.sv
// tb/tb_stack_mem_ctrl.sv - self-checking bench for stack_mem_ctrl with a behavioural dat_mem
module tb_stack_mem_ctrl;
  import stack_mem_ctrl_pkg::*;

  localparam int BASE = 255;
  localparam int CAP  = 64;   // stack slots 192..255

  logic clk;
  logic reset;
  logic fill;
  logic [7:0] sp;
  logic err_ovf, err_unf;

  stack_mem_ctrl_if bus();

  stack_mem_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .sp      (sp),
    .err_ovf (err_ovf),
    .err_unf (err_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural dat_mem: combinational read, clocked write, preloaded by fill.
  logic [7:0] dmem [256];
  int wr_count = 0;

  function automatic logic [7:0] init_val(int i);
    if (i == 65) return 8'h1E;
    return 8'((i * 37 + 11) & 255);
  endfunction

  assign bus.mem_dout = dmem[bus.mem_addr];

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 256; i++) dmem[i] <= init_val(i);
    end else if (bus.mem_wr_en) begin
      dmem[bus.mem_addr] <= bus.mem_din;
      wr_count <= wr_count + 1;
    end
  end

  // Reference model: stack as a queue (index 0 = top), memory as an array.
  logic [7:0] exp_mem [256];
  logic [7:0] stk [$];
  logic       m_ovf, m_unf;
  logic [15:0] exp_d, got_d;
  logic        exp_e, got_e;
  int          exp_lat, got_lat, exp_w, got_w;
  logic [7:0]  exp_sp;

  int checks = 0;
  int errors = 0;

  task automatic model_step(input logic [2:0] op, input logic [7:0] a, input logic [15:0] wd);
    int n;
    logic [7:0] lo, hi;
    n = stk.size();
    exp_d = 16'd0; exp_e = 1'b0; exp_lat = 1; exp_w = 0;
    case (op)
      3'd0: exp_d = {8'h00, exp_mem[a]};
      3'd1: begin exp_mem[a] = wd[7:0]; exp_w = 1; end
      3'd2: if (n < CAP) begin
              exp_mem[BASE - n] = wd[7:0]; stk.push_front(wd[7:0]); exp_w = 1;
            end else begin exp_e = 1'b1; m_ovf = 1'b1; end
      3'd3: if (n >= 1) exp_d = {8'h00, stk.pop_front()};
            else begin exp_e = 1'b1; m_unf = 1'b1; end
      3'd4: if (n <= CAP - 2) begin
              exp_mem[BASE - n] = wd[15:8]; exp_mem[BASE - n - 1] = wd[7:0];
              stk.push_front(wd[15:8]); stk.push_front(wd[7:0]);
              exp_lat = 2; exp_w = 2;
            end else begin exp_e = 1'b1; m_ovf = 1'b1; end
      3'd5: if (n >= 2) begin
              lo = stk.pop_front(); hi = stk.pop_front();
              exp_d = {hi, lo}; exp_lat = 2;
            end else begin exp_e = 1'b1; m_unf = 1'b1; end
      default: exp_e = 1'b1;
    endcase
    exp_sp = 8'(BASE - stk.size());
  endtask

  // Drives one request immediately (caller is away from the clock edge) and
  // waits a bounded number of cycles for its response.
  task automatic do_req(input logic [2:0] op, input logic [7:0] a, input logic [15:0] wd);
    int w0;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_at_issue got %b exp 1", bus.req_ready);
    end
    w0 = wr_count;
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    got_lat = 1;
    while (bus.rsp_valid !== 1'b1 && got_lat < 5) begin
      @(posedge clk); #1;
      got_lat++;
    end
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rsp_timeout op=%0d got no rsp_valid exp rsp within 5 cycles", op);
    end
    got_d = bus.rsp_data;
    got_e = bus.rsp_err;
    got_w = wr_count - w0;
  endtask

  task automatic run(input logic [2:0] op, input logic [7:0] a, input logic [15:0] wd);
    model_step(op, a, wd);
    do_req(op, a, wd);
  endtask

  task automatic do_reset();
    bus.req_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    stk.delete();
    m_ovf = 1'b0; m_unf = 1'b0;
    exp_sp = 8'(BASE);
  endtask

  task automatic test_reset();
    do_reset();
    checks += 7;
    if (sp !== 8'd255)        begin errors++; $display("FAIL reset_sp got %0d exp 255", sp); end
    if (bus.req_ready !== 1)  begin errors++; $display("FAIL reset_ready got %b exp 1", bus.req_ready); end
    if (bus.rsp_valid !== 0)  begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", bus.rsp_valid); end
    if (bus.rsp_data !== 0)   begin errors++; $display("FAIL reset_rsp_data got %h exp 0", bus.rsp_data); end
    if (bus.rsp_err !== 0)    begin errors++; $display("FAIL reset_rsp_err got %b exp 0", bus.rsp_err); end
    if (err_ovf !== 0 || err_unf !== 0) begin errors++; $display("FAIL reset_flags got %b%b exp 00", err_ovf, err_unf); end
    if (bus.mem_wr_en !== 0)  begin errors++; $display("FAIL reset_wr_en got %b exp 0", bus.mem_wr_en); end
  endtask

  task automatic test_load_store();
    run(3'd0, 8'd65, 16'h0);
    checks += 4;
    if (got_d !== 16'h001E) begin errors++; $display("FAIL ld65_data got %h exp 001E", got_d); end
    if (got_lat != 1)       begin errors++; $display("FAIL ld65_lat got %0d exp 1", got_lat); end
    if (got_e !== 1'b0)     begin errors++; $display("FAIL ld65_err got %b exp 0", got_e); end
    if (sp !== 8'd255)      begin errors++; $display("FAIL ld65_sp got %0d exp 255", sp); end
    run(3'd1, 8'd10, 16'hFF5A);
    checks += 2;
    if (got_w != 1 || dmem[10] !== 8'h5A) begin errors++; $display("FAIL st10 got w=%0d m=%h exp w=1 m=5A", got_w, dmem[10]); end
    if (got_d !== 16'h0 || got_lat != 1)  begin errors++; $display("FAIL st10_rsp got d=%h lat=%0d exp d=0 lat=1", got_d, got_lat); end
    run(3'd0, 8'd10, 16'h0);
    checks++;
    if (got_d !== 16'h005A) begin errors++; $display("FAIL ld10_data got %h exp 005A", got_d); end
  endtask

  task automatic test_push_pop();
    run(3'd2, 8'd0, 16'h00A5);
    checks++;
    if (sp !== 8'd254 || dmem[255] !== 8'hA5) begin errors++; $display("FAIL push_a5 got sp=%0d m=%h exp sp=254 m=A5", sp, dmem[255]); end
    run(3'd2, 8'd0, 16'h003C);
    checks++;
    if (sp !== 8'd253 || dmem[254] !== 8'h3C) begin errors++; $display("FAIL push_3c got sp=%0d m=%h exp sp=253 m=3C", sp, dmem[254]); end
    run(3'd3, 8'd0, 16'h0);
    checks++;
    if (got_d !== 16'h003C || sp !== 8'd254) begin errors++; $display("FAIL pop_3c got d=%h sp=%0d exp d=003C sp=254", got_d, sp); end
    run(3'd3, 8'd0, 16'h0);
    checks++;
    if (got_d !== 16'h00A5 || sp !== 8'd255 || got_lat != 1) begin errors++; $display("FAIL pop_a5 got d=%h sp=%0d lat=%0d exp d=00A5 sp=255 lat=1", got_d, sp, got_lat); end
  endtask

  task automatic test_push2_pop2();
    run(3'd4, 8'd0, 16'hBEEF);
    checks += 3;
    if (dmem[255] !== 8'hBE || dmem[254] !== 8'hEF) begin errors++; $display("FAIL push2_mem got %h%h exp BEEF", dmem[255], dmem[254]); end
    if (got_lat != 2 || got_w != 2) begin errors++; $display("FAIL push2_timing got lat=%0d w=%0d exp lat=2 w=2", got_lat, got_w); end
    if (sp !== 8'd253) begin errors++; $display("FAIL push2_sp got %0d exp 253", sp); end
    run(3'd5, 8'd0, 16'h0);
    checks += 2;
    if (got_d !== 16'hBEEF || got_lat != 2) begin errors++; $display("FAIL pop2 got d=%h lat=%0d exp d=BEEF lat=2", got_d, got_lat); end
    if (sp !== 8'd255 || got_e !== 1'b0) begin errors++; $display("FAIL pop2_sp got sp=%0d e=%b exp sp=255 e=0", sp, got_e); end
  endtask

  task automatic test_underflow();
    run(3'd3, 8'd0, 16'h0);
    checks += 2;
    if (got_e !== 1'b1 || got_d !== 16'h0 || err_unf !== 1'b1) begin errors++; $display("FAIL pop_empty got e=%b d=%h unf=%b exp e=1 d=0 unf=1", got_e, got_d, err_unf); end
    if (sp !== 8'd255 || got_w != 0) begin errors++; $display("FAIL pop_empty_side got sp=%0d w=%0d exp sp=255 w=0", sp, got_w); end
    run(3'd2, 8'd0, 16'h0011);
    run(3'd5, 8'd0, 16'h0);
    checks++;
    if (got_e !== 1'b1 || got_lat != 1 || sp !== 8'd254) begin errors++; $display("FAIL pop2_short got e=%b lat=%0d sp=%0d exp e=1 lat=1 sp=254", got_e, got_lat, sp); end
    run(3'd3, 8'd0, 16'h0);
    checks++;
    if (got_d !== 16'h0011 || err_unf !== 1'b1) begin errors++; $display("FAIL unf_sticky got d=%h unf=%b exp d=0011 unf=1", got_d, err_unf); end
    run(3'd6, 8'd0, 16'h1234);
    checks++;
    if (got_e !== 1'b1 || got_w != 0 || err_unf !== 1'b1 || err_ovf !== 1'b0 || sp !== 8'd255) begin
      errors++; $display("FAIL illegal6 got e=%b w=%0d unf=%b ovf=%b sp=%0d exp e=1 w=0 unf=1 ovf=0 sp=255", got_e, got_w, err_unf, err_ovf, sp);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 63; i++) run(3'd2, 8'd0, 16'($urandom));
    checks++;
    if (sp !== 8'd192) begin errors++; $display("FAIL fill63_sp got %0d exp 192", sp); end
    run(3'd4, 8'd0, 16'h1357);
    checks += 2;
    if (got_e !== 1'b1 || err_ovf !== 1'b1 || got_w != 0) begin errors++; $display("FAIL push2_full got e=%b ovf=%b w=%0d exp e=1 ovf=1 w=0", got_e, err_ovf, got_w); end
    if (got_lat != 1 || sp !== 8'd192) begin errors++; $display("FAIL push2_full_side got lat=%0d sp=%0d exp lat=1 sp=192", got_lat, sp); end
    run(3'd2, 8'd0, 16'h0077);
    checks++;
    if (dmem[192] !== 8'h77 || sp !== 8'd191 || got_e !== 1'b0) begin errors++; $display("FAIL push_last got m=%h sp=%0d e=%b exp m=77 sp=191 e=0", dmem[192], sp, got_e); end
    run(3'd2, 8'd0, 16'h0088);
    checks++;
    if (got_e !== 1'b1 || sp !== 8'd191 || got_w != 0) begin errors++; $display("FAIL push_full got e=%b sp=%0d w=%0d exp e=1 sp=191 w=0", got_e, sp, got_w); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req_valid = 1'b1; bus.req_op = 3'd4; bus.req_wdata = 16'hC0DE; bus.req_addr = 8'd0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checks++;
    if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL in_second_ready got %b exp 0", bus.req_ready); end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || sp !== 8'd255 || bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset got v=%b sp=%0d rdy=%b exp v=0 sp=255 rdy=1", bus.rsp_valid, sp, bus.req_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    exp_mem[255] = 8'hC0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_stray_rsp got 1 exp 0"); end
    end
    checks++;
    if (dmem[254] === 8'hDE) begin errors++; $display("FAIL mid_reset_lo_write got DE exp no write"); end
    run(3'd7, 8'd0, 16'h0);
    checks++;
    if (got_e !== 1'b1 || err_ovf !== 1'b0 || err_unf !== 1'b0 || got_lat != 1) begin
      errors++; $display("FAIL illegal7 got e=%b ovf=%b unf=%b lat=%0d exp e=1 ovf=0 unf=0 lat=1", got_e, err_ovf, err_unf, got_lat);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      run(3'(i % 2), 8'($urandom_range(0, 191)), 16'($urandom));
      checks++;
      if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b1 || got_lat != 1) begin
        errors++; $display("FAIL b2b_%0d got rdy=%b v=%b lat=%0d exp rdy=1 v=1 lat=1", i, bus.req_ready, bus.rsp_valid, got_lat);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [7:0] a;
    int r;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r  = $urandom_range(0, 9);
      op = (r > 7) ? 3'd2 : 3'(r);
      a  = (op == 3'd1) ? 8'($urandom_range(0, 191)) : 8'($urandom);
      run(op, a, 16'($urandom));
      checks++;
      if (got_d !== exp_d || got_e !== exp_e || got_lat != exp_lat || got_w != exp_w) begin
        errors++; $display("FAIL rand_rsp i=%0d op=%0d got d=%h e=%b lat=%0d w=%0d exp d=%h e=%b lat=%0d w=%0d",
                           i, op, got_d, got_e, got_lat, got_w, exp_d, exp_e, exp_lat, exp_w);
      end
      checks++;
      if (sp !== exp_sp || err_ovf !== m_ovf || err_unf !== m_unf) begin
        errors++; $display("FAIL rand_state i=%0d got sp=%0d ovf=%b unf=%b exp sp=%0d ovf=%b unf=%b",
                           i, sp, err_ovf, err_unf, exp_sp, m_ovf, m_unf);
      end
    end
    for (int j = 0; j < 256; j++) begin
      checks++;
      if (dmem[j] !== exp_mem[j]) begin errors++; $display("FAIL rand_mem addr=%0d got %h exp %h", j, dmem[j], exp_mem[j]); end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_addr = 8'd0; bus.req_wdata = 16'd0;
    reset = 1'b1;
    fill  = 1'b1;
    for (int i = 0; i < 256; i++) exp_mem[i] = init_val(i);
    @(posedge clk); #1;
    fill = 1'b0;
    test_reset();
    test_load_store();
    test_push_pop();
    test_push2_pop2();
    test_underflow();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
